// File: rtl/crop_capture_ctrl_if.sv
// Camera-capture bus between the crop/downsample path, the capture controller and the image buffer.
// The slave modport is the controller side; oState exposes the controller FSM for observation.
interface crop_capture_ctrl_if #(
   parameter int AW = 10
);
   logic          iStart;
   logic          iSOF;
   logic          iPxlVal;
   logic [7:0]    iPxl;
   logic          iAck;
   logic          oBufRst;
   logic          oWrEn;
   logic [AW-1:0] oWrAddr;
   logic [7:0]    oWrData;
   logic          oBusy;
   logic          oDone;
   logic          oErr;
   logic [1:0]    oState;

   // Handshake: iPxl is valid only while iPxlVal is high; every iPxlVal cycle in CAPTURE
   // yields exactly one oWrEn cycle one clock later. There is no backpressure (no ready).
   modport slave (
      input  iStart, iSOF, iPxlVal, iPxl, iAck,
      output oBufRst, oWrEn, oWrAddr, oWrData, oBusy, oDone, oErr, oState
   );

   modport master (
      output iStart, iSOF, iPxlVal, iPxl, iAck,
      input  oBufRst, oWrEn, oWrAddr, oWrData, oBusy, oDone, oErr, oState
   );
endinterface

// File: rtl/crop_capture_ctrl.sv
// Captures one NPIX-pixel image from the crop stage into an image buffer, frame-aligned on iSOF.
// Optional idle timeout in ARM/CAPTURE is enabled by defining CAP_TIMEOUT_EN.
module crop_capture_ctrl #(
   parameter int NPIX    = 784,
   parameter int AW      = 10,
   parameter int TIMEOUT = 1000000
) (
   input logic              iCLK,
   input logic              iRST,
   crop_capture_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

   if ((2 ** AW) < NPIX || TIMEOUT < 2) begin : g_bad_params
      $error("crop_capture_ctrl: AW too narrow for NPIX or TIMEOUT below 2");
   end

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] count_q, count_d;
   logic          buf_rst_q, buf_rst_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          err_q, err_d;
   logic [AW-1:0] pix_addr;

   // A pixel arriving with a new SOF is the first pixel of the restarted frame.
   assign pix_addr = bus.iSOF ? '0 : count_q;

`ifdef CAP_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      buf_rst_d = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (bus.iStart) begin
            state_d   = ARM;
            buf_rst_d = 1'b1;
            err_d     = 1'b0;
         end
         ARM: if (bus.iSOF) begin
            state_d = CAPTURE;
            count_d = '0;
         end
         CAPTURE: begin
            if (bus.iSOF) begin
               err_d   = 1'b1;
               count_d = '0;
            end
            if (bus.iPxlVal) begin
               wr_en_d   = 1'b1;
               wr_addr_d = pix_addr;
               wr_data_d = bus.iPxl;
               // The final write never increments, so the count cannot pass NPIX-1.
               if (pix_addr == LAST_ADDR) begin
                  state_d = DONE;
                  count_d = '0;
               end else begin
                  count_d = pix_addr + 1'b1;
               end
            end
         end
         default: if (bus.iAck) begin
            if (bus.iStart) begin
               state_d   = ARM;
               buf_rst_d = 1'b1;
               err_d     = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
      endcase

`ifdef CAP_TIMEOUT_EN
      tmo_d = tmo_q;
      if ((state_q == ARM || state_q == CAPTURE) && !(state_q == CAPTURE && bus.iPxlVal) &&
          tmo_q == TMO_LAST) begin
         state_d = IDLE;
         err_d   = 1'b1;
         count_d = '0;
         tmo_d   = '0;
      end else if ((state_d == ARM && state_q != ARM) || (state_q == CAPTURE && bus.iPxlVal)) begin
         tmo_d = '0;
      end else if (state_q == ARM || state_q == CAPTURE) begin
         tmo_d = tmo_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q   <= IDLE;
         count_q   <= '0;
         buf_rst_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         buf_rst_q <= buf_rst_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

`ifdef CAP_TIMEOUT_EN
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) tmo_q <= '0;
      else      tmo_q <= tmo_d;
   end
`endif

   assign bus.oBufRst = buf_rst_q;
   assign bus.oWrEn   = wr_en_q;
   assign bus.oWrAddr = wr_addr_q;
   assign bus.oWrData = wr_data_q;
   assign bus.oBusy   = (state_q == ARM) || (state_q == CAPTURE);
   assign bus.oDone   = (state_q == DONE);
   assign bus.oErr    = err_q;
   assign bus.oState  = state_q;
endmodule

// File: tb/tb_crop_capture_ctrl.sv
// Bench for crop_capture_ctrl: directed capture scenarios with a write scoreboard.
// The timeout scenario is included when CAP_TIMEOUT_EN is defined.
module tb_crop_capture_ctrl;
   localparam int NPIX = 784;
   localparam int AW   = 10;
   localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_DONE = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [AW+7:0] exp_q[$];

   crop_capture_ctrl_if #(.AW(AW)) ifc ();

   crop_capture_ctrl #(.NPIX(NPIX), .AW(AW), .TIMEOUT(16)) dut (
      .iCLK(clk),
      .iRST(rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input logic [7:0] d, input bit expect_wr, input logic [AW-1:0] a);
      ifc.iPxlVal = 1'b1;
      ifc.iPxl    = d;
      if (expect_wr) exp_q.push_back({a, d});
      cycle();
      ifc.iPxlVal = 1'b0;
   endtask

   task automatic pulse_sof();
      ifc.iSOF = 1'b1;
      cycle();
      ifc.iSOF = 1'b0;
   endtask

   task automatic start();
      ifc.iStart = 1'b1;
      cycle();
      ifc.iStart = 1'b0;
   endtask

   task automatic frame(input int first, input int last);
      for (int a = first; a <= last; a++) begin
         logic [AW-1:0] addr;
         addr = AW'(a);
         px(addr[7:0], 1'b1, addr);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " oBufRst"}, 32'(ifc.oBufRst), 0);
      check({tag, " oWrEn"},   32'(ifc.oWrEn),   0);
      check({tag, " oWrAddr"}, 32'(ifc.oWrAddr), 0);
      check({tag, " oWrData"}, 32'(ifc.oWrData), 0);
      check({tag, " oBusy"},   32'(ifc.oBusy),   0);
      check({tag, " oDone"},   32'(ifc.oDone),   0);
      check({tag, " oErr"},    32'(ifc.oErr),    0);
   endtask

   // Scoreboard monitor: every write the DUT presents must match the next expected write.
   always @(negedge clk) begin
      if (ifc.oWrEn === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected: got addr=%0d data=0x%0h expected no write", ifc.oWrAddr, ifc.oWrData);
         end else begin
            logic [AW+7:0] e;
            e = exp_q.pop_front();
            if ({ifc.oWrAddr, ifc.oWrData} !== e) begin
               failures++;
               $display("FAIL wr_data: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                        ifc.oWrAddr, ifc.oWrData, e[AW+7:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      ifc.iStart = 1'b0; ifc.iSOF = 1'b0; ifc.iPxlVal = 1'b0; ifc.iPxl = '0; ifc.iAck = 1'b0;
      repeat (3) cycle();
      check_all_zero("reset");
      check("reset state", 32'(ifc.oState), 32'(S_IDLE));
      rst = 1'b0;
      cycle();

      // Full image; pixels during ARM are dropped.
      start();
      check("start bufrst", 32'(ifc.oBufRst), 1);
      check("start busy", 32'(ifc.oBusy), 1);
      cycle();
      check("bufrst one cycle", 32'(ifc.oBufRst), 0);
      for (int i = 0; i < 3; i++) px(8'hEE, 1'b0, '0);
      pulse_sof();
      frame(0, NPIX - 1);
      check("full done", 32'(ifc.oDone), 1);
      check("full err", 32'(ifc.oErr), 0);
      check("full busy", 32'(ifc.oBusy), 0);
      px(8'h11, 1'b0, '0);
      pulse_sof();
      check("done ignores sof", 32'(ifc.oDone), 1);
      check("done err clean", 32'(ifc.oErr), 0);
      ifc.iAck = 1'b1;
      cycle();
      ifc.iAck = 1'b0;
      check("ack idle", 32'(ifc.oState), 32'(S_IDLE));
      check("ack no bufrst", 32'(ifc.oBufRst), 0);

      // Short frame: SOF after 100 pixels restarts at address 0 and flags an error.
      start();
      pulse_sof();
      frame(0, 99);
      ifc.iStart = 1'b1; ifc.iAck = 1'b1;
      cycle();
      ifc.iStart = 1'b0; ifc.iAck = 1'b0;
      check("capture ignores start", 32'(ifc.oBufRst), 0);
      check("capture ignores ack", 32'(ifc.oBusy), 1);
      pulse_sof();
      check("short frame err", 32'(ifc.oErr), 1);
      frame(0, NPIX - 1);
      check("short done", 32'(ifc.oDone), 1);
      check("short err sticky", 32'(ifc.oErr), 1);

      // Ack and start together in DONE re-arm immediately.
      ifc.iAck = 1'b1; ifc.iStart = 1'b1;
      cycle();
      ifc.iAck = 1'b0; ifc.iStart = 1'b0;
      check("b2b bufrst", 32'(ifc.oBufRst), 1);
      check("b2b state", 32'(ifc.oState), 32'(S_ARM));
      check("b2b err cleared", 32'(ifc.oErr), 0);
      for (int i = 0; i < 4; i++) px(8'h5A, 1'b0, '0);
      pulse_sof();
      frame(0, 49);
      ifc.iSOF = 1'b1;
      px(8'hA5, 1'b1, '0);
      ifc.iSOF = 1'b0;
      check("sof+pixel err", 32'(ifc.oErr), 1);
      frame(1, NPIX - 1);
      check("b2b done", 32'(ifc.oDone), 1);
      check("b2b state done", 32'(ifc.oState), 32'(S_DONE));
      ifc.iAck = 1'b1;
      cycle();
      ifc.iAck = 1'b0;

      // Reset in the middle of a capture abandons it.
      start();
      pulse_sof();
      frame(0, 299);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async reset");
      repeat (2) cycle();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) px(8'(i), 1'b0, '0);
      pulse_sof();
      for (int i = 0; i < 5; i++) px(8'(i), 1'b0, '0);
      check("no start busy", 32'(ifc.oBusy), 0);
      check("no start state", 32'(ifc.oState), 32'(S_IDLE));

`ifdef CAP_TIMEOUT_EN
      start();
      repeat (15) cycle();
      check("tmo still busy", 32'(ifc.oBusy), 1);
      cycle();
      check("tmo busy", 32'(ifc.oBusy), 0);
      check("tmo err", 32'(ifc.oErr), 1);
      check("tmo state", 32'(ifc.oState), 32'(S_IDLE));
`endif

      repeat (3) cycle();
      check("scoreboard drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/crop_capture_ctrl.md
CROP_CAPTURE_CTRL -- requirements
Module: crop_capture_ctrl

Interface
REQ-001 Parameter NPIX, default 784, is the number of sampled pixels per captured image (28x28).
REQ-002 Parameter AW, default 10, is the write-address width; 2^AW SHALL be at least NPIX.
REQ-003 Parameter TIMEOUT, default 1000000, is the idle-cycle limit used only when CAP_TIMEOUT_EN is defined.
REQ-004 Port iCLK, input, 1: sole clock; all state SHALL update on the rising edge.
REQ-005 Port iRST, input, 1: reset, asynchronous and active-high.
REQ-006 Port iStart, input, 1: level request to capture one image.
REQ-007 Port iSOF, input, 1: single-cycle start-of-frame pulse from the camera path.
REQ-008 Port iPxlVal, input, 1: sampled-pixel strobe from the crop/downsample stage.
REQ-009 Port iPxl, input, 8: sampled gray pixel, qualified by iPxlVal.
REQ-010 Port iAck, input, 1: consumer acknowledges a completed image.
REQ-011 Port oBufRst, output, 1: one-cycle pulse clearing the downstream buffer and crop stage.
REQ-012 Port oWrEn, output, 1: image-buffer write enable.
REQ-013 Port oWrAddr, output, AW: image-buffer write address.
REQ-014 Port oWrData, output, 8: image-buffer write data.
REQ-015 Port oBusy, output, 1: high in ARM or CAPTURE.
REQ-016 Port oDone, output, 1: high in DONE.
REQ-017 Port oErr, output, 1: sticky error flag.

Function
REQ-018 The FSM SHALL have four states: IDLE, ARM, CAPTURE, DONE.
REQ-019 IDLE + iStart -> ARM; oBufRst pulses for exactly the cycle after acceptance; oErr clears on acceptance.
REQ-020 ARM SHALL ignore iPxlVal; iSOF -> CAPTURE with the pixel count cleared to 0.
REQ-021 In CAPTURE each iPxlVal cycle SHALL produce, one cycle later, oWrEn=1, oWrAddr=count, oWrData=iPxl, then count+1.
REQ-022 The write of count NPIX-1 SHALL move the FSM to DONE in the same edge; oDone rises one cycle after that write's iPxlVal.
REQ-023 iSOF in CAPTURE with count < NPIX (short frame) SHALL set oErr, clear count to 0 and stay in CAPTURE; iSOF together with iPxlVal SHALL take the pixel as address 0.
REQ-024 DONE SHALL ignore iPxlVal and iSOF; iAck -> IDLE; iAck and iStart in the same cycle -> ARM with oBufRst pulse (back-to-back capture).
REQ-025 iStart outside IDLE/DONE and iAck outside DONE SHALL be ignored.
REQ-026 oWrEn SHALL never be high outside CAPTURE-originated writes; no address SHALL exceed NPIX-1.
REQ-027 The count SHALL be AW bits wide, unsigned, and never wrap.

Reset
REQ-028 While iRST is high: state=IDLE, count=0, oBufRst=0, oWrEn=0, oWrAddr=0, oWrData=0, oBusy=0, oDone=0, oErr=0.
REQ-029 Reset mid-CAPTURE SHALL abandon the image immediately with no further writes; the first action after release SHALL require a new iStart.

Configuration
REQ-030 With CAP_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to ARM and on each accepted pixel, and on reaching TIMEOUT-1 in ARM or CAPTURE SHALL force IDLE and set oErr.
REQ-031 Without CAP_TIMEOUT_EN, no timeout logic SHALL exist, and ARM/CAPTURE SHALL wait indefinitely.

Verification
REQ-032 iStart, iSOF, 784 iPxlVal pulses with iPxl=addr[7:0] -> 784 writes at addr 0..783 with matching data, oDone high, oErr=0.
REQ-033 iSOF after 100 pixels in CAPTURE -> oErr=1, next pixel written at addr 0, completion after 784 more.
REQ-034 iAck and iStart in the same cycle in DONE -> oBufRst pulse, state ARM, pixels before the next iSOF not written.
REQ-035 iRST asserted after 300 pixels -> all outputs 0 asynchronously; pixels without a new iStart produce no oWrEn.
REQ-036 With CAP_TIMEOUT_EN defined and TIMEOUT=16: iStart with no iSOF for 16 cycles -> IDLE, oErr=1, oBusy=0.
